// File: rtl/key_event_pkg.sv
// Shared types for the key event controller: event codes and per-key FSM states.
package key_event_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_HOLD    = 2'd2,
        EVT_REPEAT  = 2'd3
    } evt_code_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } key_state_t;

endpackage

// File: rtl/key_event_ctrl_if.sv
// Event output channel of key_event_ctrl: valid/ready head plus the drop pulse.
interface key_event_ctrl_if #(
    parameter int KEY_WIDTH = 2
);
    logic                 evt_valid;
    logic                 evt_ready;
    logic [KEY_WIDTH-1:0] evt_key;
    logic [1:0]           evt_code;
    logic                 dropped;

    modport master (
        output evt_valid,
        output evt_key,
        output evt_code,
        output dropped,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_key,
        input  evt_code,
        input  dropped,
        output evt_ready
    );
endinterface

// File: rtl/key_event_fifo.sv
// First-word-fall-through FIFO; the head stays on pop_data while empty until overwritten.
module key_event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates full (bits differ) from empty (bits equal).
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Turns debounced key levels into PRESS/RELEASE/HOLD/REPEAT events, arbitrated
// round-robin from per-key pending slots into a FWFT event FIFO.
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS      = 4,
    parameter int KEY_WIDTH     = 2,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int TIMER_WIDTH   = 25,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_in,
    key_event_ctrl_if.master    evt_if
);
    logic [NUM_KEYS-1:0]      keys_prev;
    logic [NUM_KEYS-1:0]      rise;
    logic [NUM_KEYS-1:0]      fall;
    logic [NUM_KEYS-1:0]      slot_valid;
    logic [NUM_KEYS-1:0][1:0] slot_code;
    logic [NUM_KEYS-1:0]      grant_vec;
    logic [NUM_KEYS-1:0]      drop_vec;
    logic                     grant_any;
    logic [KEY_WIDTH-1:0]     grant_idx;
    logic [KEY_WIDTH-1:0]     rr_ptr;
    logic                     dropped_q;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [KEY_WIDTH+1:0]     head_data;

    assign rise = keys_in & ~keys_prev;
    assign fall = ~keys_in & keys_prev;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_state_t             state;
        logic [TIMER_WIDTH-1:0] timer;
        logic                   gen;
        evt_code_t              gen_code;
        logic                   pend_valid;
        evt_code_t              pend_code;
        logic                   hold_hit;
        logic                   rep_hit;

        assign hold_hit = (timer == TIMER_WIDTH'(HOLD_CYCLES - 1));
        assign rep_hit  = (timer == TIMER_WIDTH'(REPEAT_CYCLES - 1));

        // Release wins over a timer expiry landing in the same cycle.
        always_comb begin
            gen      = 1'b0;
            gen_code = EVT_PRESS;
            unique case (state)
                ST_IDLE: begin
                    if (rise[k]) begin
                        gen      = 1'b1;
                        gen_code = EVT_PRESS;
                    end
                end
                ST_PRESSED: begin
                    if (fall[k]) begin
                        gen      = 1'b1;
                        gen_code = EVT_RELEASE;
                    end else if (hold_hit) begin
                        gen      = 1'b1;
                        gen_code = EVT_HOLD;
                    end
                end
                ST_HELD: begin
                    if (fall[k]) begin
                        gen      = 1'b1;
                        gen_code = EVT_RELEASE;
                    end else if (rep_hit) begin
                        gen      = 1'b1;
                        gen_code = EVT_REPEAT;
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state      <= ST_IDLE;
                timer      <= '0;
                pend_valid <= 1'b0;
                pend_code  <= EVT_PRESS;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        timer <= '0;
                        if (rise[k]) state <= ST_PRESSED;
                    end
                    ST_PRESSED: begin
                        if (fall[k]) begin
                            state <= ST_IDLE;
                            timer <= '0;
                        end else if (hold_hit) begin
                            state <= ST_HELD;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (fall[k]) begin
                            state <= ST_IDLE;
                            timer <= '0;
                        end else if (rep_hit) begin
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end
                endcase

                if (gen) begin
                    pend_valid <= 1'b1;
                    pend_code  <= gen_code;
                end else if (grant_vec[k]) begin
                    pend_valid <= 1'b0;
                end
            end
        end

        assign slot_valid[k] = pend_valid;
        assign slot_code[k]  = pend_code;
        assign grant_vec[k]  = grant_any && (grant_idx == KEY_WIDTH'(k));
        assign drop_vec[k]   = gen && pend_valid && !grant_vec[k];
    end

    // Search begins at rr_ptr; the full flag comes from registered pointers only.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + i) % NUM_KEYS;
            if (!grant_any && !fifo_full && slot_valid[idx[KEY_WIDTH-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = idx[KEY_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys_prev <= '0;
            rr_ptr    <= '0;
            dropped_q <= 1'b0;
        end else begin
            keys_prev <= keys_in;
            dropped_q <= |drop_vec;
            if (grant_any) begin
                rr_ptr <= (int'(grant_idx) == NUM_KEYS - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    key_event_fifo #(
        .WIDTH(KEY_WIDTH + 2),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (grant_any),
        .push_data({grant_idx, slot_code[grant_idx]}),
        .full     (fifo_full),
        .pop      (evt_if.evt_valid && evt_if.evt_ready),
        .pop_data (head_data),
        .empty    (fifo_empty)
    );

    assign evt_if.evt_valid = !fifo_empty;
    assign evt_if.evt_key   = head_data[KEY_WIDTH+1:2];
    assign evt_if.evt_code  = head_data[1:0];
    assign evt_if.dropped   = dropped_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: per-cycle key/ready schedules, logged pops
// compared against hand-derived event cycles.
module tb_key_event_ctrl;
    import key_event_pkg::*;

    localparam int NK = 4;
    localparam int KW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] keys_in;

    key_event_ctrl_if #(.KEY_WIDTH(KW)) evt_if ();

    key_event_ctrl #(
        .NUM_KEYS     (NK),
        .KEY_WIDTH    (KW),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .TIMER_WIDTH  (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .keys_in(keys_in),
        .evt_if (evt_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [NK-1:0] pat [64];
    logic          rdy [64];
    int            log_cyc  [32];
    int            log_key  [32];
    int            log_code [32];
    int            n_log;
    int            n_drop;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_pat(input int lo, input int hi, input logic [NK-1:0] v, input logic r);
        for (int i = lo; i <= hi; i++) begin
            pat[i] = v;
            rdy[i] = r;
        end
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        keys_in         = '0;
        evt_if.evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Cycle c: drive inputs just after the edge, sample mid-cycle, then advance.
    task automatic run_log(input int ncyc);
        logic          have_prev;
        logic [KW+1:0] prev_head;
        n_log     = 0;
        n_drop    = 0;
        have_prev = 1'b0;
        prev_head = '0;
        for (int i = 0; i < 32; i++) begin
            log_cyc[i]  = -1;
            log_key[i]  = -1;
            log_code[i] = -1;
        end
        for (int c = 0; c < ncyc; c++) begin
            keys_in          = pat[c];
            evt_if.evt_ready = rdy[c];
            #2;
            if (have_prev && evt_if.evt_valid)
                check_val("head_stable", 32'({evt_if.evt_key, evt_if.evt_code}), 32'(prev_head));
            have_prev = evt_if.evt_valid && !evt_if.evt_ready;
            prev_head = {evt_if.evt_key, evt_if.evt_code};
            if (evt_if.dropped) n_drop++;
            if (evt_if.evt_valid && evt_if.evt_ready && n_log < 32) begin
                log_cyc[n_log]  = c;
                log_key[n_log]  = int'(evt_if.evt_key);
                log_code[n_log] = int'(evt_if.evt_code);
                n_log++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_evt(input int i, input int cyc, input int key, input evt_code_t code);
        check_val($sformatf("evt%0d_cycle", i), 32'(log_cyc[i]), 32'(cyc));
        check_val($sformatf("evt%0d_key", i), 32'(log_key[i]), 32'(key));
        check_val($sformatf("evt%0d_code", i), 32'(log_code[i]), 32'(code));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_valid"}, 32'(evt_if.evt_valid), 32'd0);
        check_val({tag, "_key"}, 32'(evt_if.evt_key), 32'd0);
        check_val({tag, "_code"}, 32'(evt_if.evt_code), 32'd0);
        check_val({tag, "_dropped"}, 32'(evt_if.dropped), 32'd0);
    endtask

    initial begin
        reset            = 1'b1;
        keys_in          = '0;
        evt_if.evt_ready = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("reset");
        do_reset();

        // Short press of key 1.
        set_pat(0, 4, 4'b0010, 1'b1);
        set_pat(5, 63, 4'b0000, 1'b1);
        run_log(12);
        check_val("t1_count", 32'(n_log), 32'd2);
        check_val("t1_drops", 32'(n_drop), 32'd0);
        check_evt(0, 2, 1, EVT_PRESS);
        check_evt(1, 7, 1, EVT_RELEASE);

        // Long hold of key 0; release collides with a repeat expiry at cycle 20.
        do_reset();
        set_pat(0, 19, 4'b0001, 1'b1);
        set_pat(20, 63, 4'b0000, 1'b1);
        run_log(26);
        check_val("t2_count", 32'(n_log), 32'd5);
        check_val("t2_drops", 32'(n_drop), 32'd0);
        check_evt(0, 2, 0, EVT_PRESS);
        check_evt(1, 10, 0, EVT_HOLD);
        check_evt(2, 14, 0, EVT_REPEAT);
        check_evt(3, 18, 0, EVT_REPEAT);
        check_evt(4, 22, 0, EVT_RELEASE);

        // Round-robin: pointer moves past the last granted key.
        do_reset();
        set_pat(0, 5, 4'b0101, 1'b1);
        set_pat(6, 11, 4'b0000, 1'b1);
        set_pat(12, 13, 4'b0010, 1'b1);
        set_pat(14, 17, 4'b0000, 1'b1);
        set_pat(18, 63, 4'b0101, 1'b1);
        run_log(24);
        check_val("t3_count", 32'(n_log), 32'd8);
        check_val("t3_drops", 32'(n_drop), 32'd0);
        check_evt(0, 2, 0, EVT_PRESS);
        check_evt(1, 3, 2, EVT_PRESS);
        check_evt(2, 8, 0, EVT_RELEASE);
        check_evt(3, 9, 2, EVT_RELEASE);
        check_evt(4, 14, 1, EVT_PRESS);
        check_evt(5, 16, 1, EVT_RELEASE);
        check_evt(6, 20, 2, EVT_PRESS);
        check_evt(7, 21, 0, EVT_PRESS);

        // Back-pressure: FIFO fills, slots 1..3 overwritten, then drain.
        do_reset();
        set_pat(0, 0, 4'b1111, 1'b0);
        set_pat(1, 9, 4'b0000, 1'b0);
        set_pat(10, 63, 4'b0000, 1'b1);
        run_log(18);
        check_val("t4_count", 32'(n_log), 32'd5);
        check_val("t4_drop_cycles", 32'(n_drop), 32'd1);
        check_evt(0, 10, 0, EVT_PRESS);
        check_evt(1, 11, 1, EVT_RELEASE);
        check_evt(2, 12, 2, EVT_RELEASE);
        check_evt(3, 13, 3, EVT_RELEASE);
        check_evt(4, 14, 0, EVT_RELEASE);

        // Reset while HELD with PRESS/HOLD/REPEAT queued.
        do_reset();
        set_pat(0, 63, 4'b0001, 1'b0);
        run_log(15);
        check_val("t5_pre_valid", 32'(evt_if.evt_valid), 32'd1);
        check_val("t5_pre_key", 32'(evt_if.evt_key), 32'd0);
        check_val("t5_pre_code", 32'(evt_if.evt_code), 32'(EVT_PRESS));
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("t5_reset");
        reset = 1'b0;
        set_pat(0, 63, 4'b0001, 1'b1);
        run_log(6);
        check_val("t5_count", 32'(n_log), 32'd1);
        check_evt(0, 2, 0, EVT_PRESS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Converts a vector of debounced push-button levels (the `debounce` output bus) into a stream of discrete key events: PRESS, RELEASE, HOLD (long press) and auto-REPEAT. It sits between the debounce block and the software-visible register and interrupt logic. Simultaneous events from several keys go through a round-robin arbiter into a small event FIFO. The FIFO drains over a valid/ready handshake.

## Interface
- `NUM_KEYS`, 4: number of key inputs (1..16).
- `KEY_WIDTH`, 2: width of the key index, ceil(log2(NUM_KEYS)), minimum 1.
- `HOLD_CYCLES`, 25000000: cycles in PRESSED before HOLD is generated (≥2).
- `REPEAT_CYCLES`, 5000000: cycles between REPEAT events while held (≥2).
- `TIMER_WIDTH`, 25: per-key timer width; must hold max(HOLD_CYCLES, REPEAT_CYCLES)-1.
- `FIFO_DEPTH`, 4: event FIFO entries, power of two, ≥2.

Ports:
- `clk` in 1: single clock. All ports are synchronous to it.
- `reset` in 1: asynchronous, active-high reset.
- `keys_in` in NUM_KEYS: debounced key levels, 1 = pressed.
- `evt_valid` out 1: FIFO head is valid.
- `evt_ready` in 1: consumer accepts the head.
- `evt_key` out KEY_WIDTH: key index of the head event.
- `evt_code` out 2: event code of the head. 0 = PRESS, 1 = RELEASE, 2 = HOLD, 3 = REPEAT.
- `dropped` out 1: one-cycle pulse when a pending event is overwritten.

## Operation
- Edge detect: `keys_prev` registers `keys_in` every cycle.
  - Rising edge = `keys_in & ~keys_prev`.
  - Falling edge = `~keys_in & keys_prev`.
  - `keys_prev` resets to 0, so a key held through reset yields a PRESS after reset.
- Per-key FSM, states IDLE, PRESSED and HELD. The timer is cleared on every state entry and increments each cycle in PRESSED and HELD.
  - IDLE + rising edge → PRESSED; generate PRESS.
  - PRESSED with timer == HOLD_CYCLES-1 → HELD; generate HOLD.
  - HELD with timer == REPEAT_CYCLES-1 → stay in HELD, timer ← 0; generate REPEAT.
  - PRESSED/HELD + falling edge → IDLE; generate RELEASE. A falling edge takes priority over a timer expiry in the same cycle.
- Pending slot per key: one entry, valid bit plus code.
  - A generated event is written to the slot at the cycle end.
  - If the slot is still valid and not granted this cycle, the new event overwrites it and `dropped` pulses.
  - If the slot is granted in the same cycle a new event is generated, the new event is stored and no drop occurs.
- Arbiter:
  - Grants at most one valid pending slot per cycle, and only when the FIFO is not full (registered full flag; a pop in the same cycle is not credited).
  - Round-robin: search starts at the key after the last granted key. After reset, key 0 has highest priority.
  - The grant pushes {key, code} into the FIFO and clears the slot.
- FIFO: first-word-fall-through.
  - `evt_valid` = !empty.
  - Pop when `evt_valid && evt_ready`.
  - Push and pop in the same cycle are both performed.
  - Pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- `evt_key` and `evt_code` are undefined-but-stable (hold the last head) while `evt_valid` = 0. They must not change while `evt_valid && !evt_ready`.

## Timing
- Reset values:
  - FSMs IDLE, timers 0, pending slots empty, `keys_prev` 0, arbiter pointer at key 0.
  - FIFO empty.
  - Outputs `evt_valid` = 0, `evt_key` = 0, `evt_code` = 0, `dropped` = 0.
- Latency, uncontended with an empty FIFO: event generated in cycle N → pending at N+1 → granted and pushed at N+1 → `evt_valid` at N+2.
- `keys_in` rises in cycle 0:
  - PRESS appears at cycle 2.
  - HOLD is generated at cycle HOLD_CYCLES and appears at HOLD_CYCLES+2.
  - REPEATs appear every REPEAT_CYCLES after that.
- Throughput: one event per cycle in, one per cycle out.
- Reset asserted mid-operation aborts everything immediately. Events in the FIFO and pending slots are lost.

## Structure
- Shared package `key_event_pkg`:
  - event-code constants `EVT_PRESS`, `EVT_RELEASE`, `EVT_HOLD`, `EVT_REPEAT`;
  - the FSM state encoding.
- Sub-module `key_event_fifo`: parameterised FWFT FIFO with async active-high reset. It exposes push, full, pop and empty.
- The per-key FSM, timer and pending slot live in a generate loop in the top level.

## Test plan
Benches use NUM_KEYS=4, HOLD_CYCLES=8, REPEAT_CYCLES=4 and FIFO_DEPTH=4.
- Key 1 rises at cycle 0 and falls at cycle 5, with `evt_ready`=1 → {1,PRESS} valid at cycle 2, {1,RELEASE} valid at cycle 7, no HOLD, `dropped` never asserts.
- Key 0 held from cycle 0 to cycle 20 → PRESS at 2, HOLD at 10, REPEAT at 14 and 18, RELEASE at 22.
- Keys 0 and 2 rise in the same cycle, from reset → {0,PRESS} then {2,PRESS} on consecutive cycles. A later simultaneous pair of keys 0 and 2 is served 2 then 0.
- `evt_ready`=0 while keys 0–3 are each pressed and released once → FIFO fills with 4 entries, pending slots overwrite with `dropped` pulses, and `evt_valid` head stays stable. Raising `evt_ready` drains in round-robin order.
- Reset asserted in HELD state with 3 FIFO entries → outputs 0 next edge, FIFO empty. Key still high after reset release → PRESS at cycle 2 after reset deassertion.
